// File: rtl/latch_write_sequencer_pkg.sv
// Shared types for the latch write sequencer.
// Holds the FSM state encoding and the round-robin wrap helper.
package latch_write_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_OPEN  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // Next index after i, wrapping n-1 -> 0.
  function automatic int wrap_inc(
    input int i,
    input int n
  );
    return (i == n - 1) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// req/ptr in; one-hot win, index sel, valid out.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [PW-1:0] sel,
  output logic          valid
);

  int idx;

  // Walk offsets from far to near so the
  // closest set request at/after ptr wins.
  always_comb begin
    win   = '0;
    sel   = '0;
    idx   = 0;
    valid = |req;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        sel = PW'(idx);
      end
    end
    if (valid) begin
      win[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/latch_write_sequencer.sv
// Sequences round-robin writes into one shared D latch.
// clk/reset; req,wdata in; gnt,done,latch_en,latch_d,busy out.
module latch_write_sequencer
  import latch_write_sequencer_pkg::*;
#(
  parameter int N           = 4,
  parameter int W           = 8,
  parameter int OPEN_CYCLES = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic           latch_en,
  output logic [W-1:0]   latch_d,
  output logic           busy
);

  localparam int PW = $clog2(N);
  localparam int CW = $clog2(OPEN_CYCLES + 1);

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] sel;
  logic [CW-1:0] cnt;

  logic [N-1:0]  a_win;
  logic [PW-1:0] a_sel;
  logic          a_valid;

  rr_arbiter #(
    .N  (N),
    .PW (PW)
  ) u_arb (
    .req   (req),
    .ptr   (ptr),
    .win   (a_win),
    .sel   (a_sel),
    .valid (a_valid)
  );

  assign busy = (state != S_IDLE);

  // latch_d is loaded only when leaving IDLE,
  // so it is stable a cycle either side of
  // the enable pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      ptr      <= '0;
      sel      <= '0;
      cnt      <= '0;
      gnt      <= '0;
      done     <= '0;
      latch_en <= 1'b0;
      latch_d  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= '0;
          if (a_valid) begin
            sel     <= a_sel;
            gnt     <= a_win;
            latch_d <= wdata[int'(a_sel)*W +: W];
            state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          cnt      <= CW'(OPEN_CYCLES - 1);
          latch_en <= 1'b1;
          state    <= S_OPEN;
        end
        S_OPEN: begin
          if (cnt == '0) begin
            latch_en <= 1'b0;
            done     <= gnt;
            state    <= S_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_HOLD: begin
          done  <= '0;
          gnt   <= '0;
          ptr   <= PW'(wrap_inc(int'(sel), N));
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
